// File: rtl/line_delay_mtap.sv
// line_delay_mtap: multi-tap line delay for the video front end.
// One of NSRC sources is selected. It is delayed through TAPS cascaded line
// delays of DEPTH strobes each. Every tap is exposed, so a downstream window
// sees vertically aligned pixels from TAPS+1 rows.
//
// Each stage is a DEPTH-entry circular buffer. All stages share one write
// pointer. The RAM read is done before the write at the same address: the
// entry read out is the sample accepted DEPTH strobes earlier. That value is
// both the stage output and the next stage's write data.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   shift      advance strobe, one sample accepted per high cycle
//   clear      synchronous restart of fill tracking; wins over shift
//   sel        source select (out of range selects source 0)
//   sr_in      packed sources, source i at [i*WIDTH +: WIDTH]
//   tap_out    packed taps, tap k at [(k-1)*WIDTH +: WIDTH], zero until valid
//   tap_valid  bit k-1 set once tap k holds real data
//   fill_cnt   accepted shifts since reset/clear, saturating at TAPS*DEPTH+1
module line_delay_mtap #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 721,
  parameter int unsigned TAPS  = 2,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned SELW  = 1,
  parameter int unsigned CNTW  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift,
  input  logic                   clear,
  input  logic [SELW-1:0]        sel,
  input  logic [NSRC*WIDTH-1:0]  sr_in,
  output logic [TAPS*WIDTH-1:0]  tap_out,
  output logic [TAPS-1:0]        tap_valid,
  output logic [CNTW-1:0]        fill_cnt
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FillMax = TAPS * DEPTH + 1;

  logic [PW-1:0]         ptr_q;
  logic [CNTW-1:0]       fill_q, fill_inc;
  logic [TAPS-1:0]       valid_q, valid_d;
  logic [TAPS*WIDTH-1:0] tap_q, tap_d;
  logic [WIDTH-1:0]      x;
  logic [WIDTH-1:0]      rd [TAPS];
  logic [WIDTH-1:0]      wd [TAPS];
  logic                  advance;

  // clear discards a coincident strobe entirely: no pointer move, no RAM write
  assign advance = shift & ~clear;

  always_comb begin
    x = sr_in[0 +: WIDTH];
    for (int unsigned i = 1; i < NSRC; i++) begin
      if (sel == SELW'(i)) x = sr_in[i*WIDTH +: WIDTH];
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_stage
    logic [WIDTH-1:0] mem [DEPTH];

    if (k == 0) begin : g_first
      assign wd[k] = x;
    end else begin : g_next
      assign wd[k] = rd[k-1];
    end

    assign rd[k] = mem[ptr_q];

    // No reset on the RAM; stale contents are masked by tap_valid gating
    always_ff @(posedge clk) begin
      if (advance) mem[ptr_q] <= wd[k];
    end
  end

  always_comb begin
    fill_inc = (fill_q == CNTW'(FillMax)) ? fill_q : fill_q + 1'b1;
    valid_d  = '0;
    tap_d    = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      valid_d[k] = (32'(fill_inc) >= ((k + 1) * DEPTH + 1));
      tap_d[k*WIDTH +: WIDTH] = valid_d[k] ? rd[k] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      fill_q  <= '0;
      valid_q <= '0;
      tap_q   <= '0;
    end else if (clear) begin
      fill_q  <= '0;
      valid_q <= '0;
      tap_q   <= '0;
    end else if (shift) begin
      ptr_q   <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      fill_q  <= fill_inc;
      valid_q <= valid_d;
      tap_q   <= tap_d;
    end
  end

  assign tap_out   = tap_q;
  assign tap_valid = valid_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_line_delay_mtap.sv
// Bench for line_delay_mtap with DEPTH=4, TAPS=3, NSRC=3.
// The reference keeps the accepted-sample history since the last reset or
// clear. Tap k is that history read k*DEPTH samples back.
module tb_line_delay_mtap;

  localparam int W  = 11;
  localparam int D  = 4;
  localparam int T  = 3;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          shift = 1'b0;
  logic          clear = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [NS*W-1:0] sr_in = '0;
  logic [T*W-1:0]  tap_out;
  logic [T-1:0]    tap_valid;
  logic [CW-1:0]   fill_cnt;

  line_delay_mtap #(
    .WIDTH(W), .DEPTH(D), .TAPS(T), .NSRC(NS), .SELW(SW), .CNTW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .shift(shift), .clear(clear), .sel(sel),
    .sr_in(sr_in), .tap_out(tap_out), .tap_valid(tap_valid), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_acc   = 0;
  logic [W-1:0] hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] e;
    logic [T-1:0] ev;
    int ef;
    ev = '0;
    for (int k = 1; k <= T; k++) begin
      if (n_acc >= k * D + 1) begin
        e = hist[n_acc - k * D - 1];
        ev[k-1] = 1'b1;
      end else begin
        e = '0;
      end
      chk($sformatf("%s tap%0d", tag, k), 64'(tap_out[(k-1)*W +: W]), 64'(e));
    end
    chk($sformatf("%s valid", tag), 64'(tap_valid), 64'(ev));
    ef = (n_acc > T * D + 1) ? T * D + 1 : n_acc;
    chk($sformatf("%s fill", tag), 64'(fill_cnt), 64'(ef));
  endtask

  task automatic model_reset();
    n_acc = 0;
    hist.delete();
  endtask

  // One clock: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic step(input bit sh, input bit cl, input int s, input bit ramp, input string tag);
    int idx;
    @(negedge clk);
    shift = sh;
    clear = cl;
    sel   = SW'(s);
    for (int i = 0; i < NS; i++) sr_in[i*W +: W] = W'($urandom);
    if (ramp) sr_in[0 +: W] = W'(n_acc + 1);
    @(posedge clk);
    #1;
    if (cl) begin
      model_reset();
    end else if (sh) begin
      idx = (s < NS) ? s : 0;
      hist.push_back(sr_in[idx*W +: W]);
      n_acc++;
    end
    check_all(tag);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp on source 0 through several pointer wraps and saturation
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 0, 1'b1, "ramp");

    // Random sources, select including the out-of-range value 3
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b0, "sel");

    // Gapped strobes; outputs must hold across idle cycles
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, int'($urandom_range(0, 2)), 1'b0, "gap");
      repeat (2 + $urandom_range(0, 3)) step(1'b0, 1'b0, int'($urandom_range(0, 3)), 1'b0, "idle");
    end

    // Clear alone, then clear together with shift, then refill
    step(1'b0, 1'b1, 0, 1'b0, "clr");
    step(1'b1, 1'b0, 1, 1'b0, "post");
    step(1'b1, 1'b1, 2, 1'b0, "clrsh");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, int'($urandom_range(0, 2)), 1'b0, "refill");

    // Asynchronous reset pulse between edges
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b0, "pre");
    @(negedge clk);
    shift = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b0, "rst_refill");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
